// File: rtl/controle_fechadura.sv
// controle_fechadura: top-level sequencer for the digital lock.
// Gates PIN requests into the verifier, acts on its result pulses, drives the
// bolt, counts consecutive failures and applies an escalating lockout.
module controle_fechadura #(
  parameter int MAX_TENT    = 3,
  parameter int T_ABERTA    = 5,
  parameter int T_BLOQ_BASE = 30,
  parameter int RESP_TMO    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1s,
  input  logic       pin_valid,
  input  logic       senha_fail,
  input  logic       senha_padrao,
  input  logic       senha_master,
  input  logic       porta_fechada,
  input  logic       setup_done,
  output logic       verif_en,
  output logic       destrancar,
  output logic       bloqueado,
  output logic       setup_req,
  output logic [7:0] tempo_rest,
  output logic [2:0] tentativas
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_VERIF   = 3'd1,
    S_ABERTA  = 3'd2,
    S_BLOQ    = 3'd3,
    S_SETUP   = 3'd4
  } estado_t;

  localparam logic [3:0] MAX_T4    = 4'(MAX_TENT);
  localparam logic [2:0] MAX_T3    = 3'(MAX_TENT);
  localparam logic [7:0] CARGA_AB  = 8'(T_ABERTA);
  localparam logic [7:0] RESP_LIM  = 8'(RESP_TMO - 1);

  estado_t    estado, estado_n;
  logic [7:0] cnt, cnt_n;
  logic [2:0] tent, tent_n;
  logic [1:0] n_bloq, n_bloq_n;
  logic [7:0] wcnt, wcnt_n;
  logic       timeout;

  logic       verif_en_n, destrancar_n, bloqueado_n, setup_req_n;

  // Lockout length: base shifted by the lockout level, clamped to the 8-bit counter.
  function automatic logic [7:0] carga_bloq(input logic [1:0] nivel);
    logic [10:0] v;
    v = 11'(T_BLOQ_BASE) << nivel;
    return (v > 11'd255) ? 8'hFF : v[7:0];
  endfunction

  // Lockout level grows by one per lockout but never past 3.
  function automatic logic [1:0] nivel_inc(input logic [1:0] nivel);
    return (nivel == 2'd3) ? 2'd3 : nivel + 2'd1;
  endfunction

  assign timeout = (wcnt == RESP_LIM);

  // State and counter register; outputs are registered from their next values.
  always_ff @(posedge clk) begin
    if (rst) begin
      estado     <= S_IDLE;
      cnt        <= 8'd0;
      tent       <= 3'd0;
      n_bloq     <= 2'd0;
      wcnt       <= 8'd0;
      verif_en   <= 1'b1;
      destrancar <= 1'b0;
      bloqueado  <= 1'b0;
      setup_req  <= 1'b0;
    end else begin
      estado     <= estado_n;
      cnt        <= cnt_n;
      tent       <= tent_n;
      n_bloq     <= n_bloq_n;
      wcnt       <= wcnt_n;
      verif_en   <= verif_en_n;
      destrancar <= destrancar_n;
      bloqueado  <= bloqueado_n;
      setup_req  <= setup_req_n;
    end
  end

  // Next-state, countdown, failure count and lockout level.
  always_comb begin
    estado_n = estado;
    cnt_n    = cnt;
    tent_n   = tent;
    n_bloq_n = n_bloq;
    wcnt_n   = wcnt;
    case (estado)
      S_IDLE: begin
        cnt_n = 8'd0;
        if (pin_valid) begin
          estado_n = S_VERIF;
          wcnt_n   = 8'd0;
        end
      end
      S_VERIF: begin
        cnt_n = 8'd0;
        if (senha_master) begin
          estado_n = S_SETUP;
          tent_n   = 3'd0;
          n_bloq_n = 2'd0;
        end else if (senha_padrao) begin
          estado_n = S_ABERTA;
          tent_n   = 3'd0;
          n_bloq_n = 2'd0;
          cnt_n    = CARGA_AB;
        end else if (senha_fail || timeout) begin
          // A silent verifier counts the same as a rejected PIN.
          if ((4'(tent) + 4'd1) < MAX_T4) begin
            estado_n = S_IDLE;
            tent_n   = tent + 3'd1;
          end else begin
            estado_n = S_BLOQ;
            tent_n   = MAX_T3;
            cnt_n    = carga_bloq(n_bloq);
            n_bloq_n = nivel_inc(n_bloq);
          end
        end else begin
          wcnt_n = wcnt + 8'd1;
        end
      end
      S_ABERTA: begin
        // Once the window expires the bolt stays shut; only a closed door releases.
        if (cnt == 8'd0) begin
          if (porta_fechada) estado_n = S_IDLE;
        end else if (tick_1s) begin
          cnt_n = cnt - 8'd1;
        end
      end
      S_BLOQ: begin
        if (cnt == 8'd0) begin
          estado_n = S_IDLE;
          tent_n   = 3'd0;
        end else if (tick_1s) begin
          cnt_n = cnt - 8'd1;
        end
      end
      S_SETUP: begin
        if (setup_done) estado_n = S_IDLE;
      end
      default: begin
        estado_n = S_IDLE;
        cnt_n    = 8'd0;
      end
    endcase
  end

  // Output decode from the upcoming state so the registered outputs track it.
  always_comb begin
    verif_en_n   = (estado_n == S_IDLE);
    destrancar_n = (estado_n == S_ABERTA) && (cnt_n != 8'd0);
    bloqueado_n  = (estado_n == S_BLOQ);
    setup_req_n  = (estado_n == S_SETUP);
  end

  assign tempo_rest = cnt;
  assign tentativas = tent;

endmodule
